// File: rtl/fetch_stage.sv
// fetch_stage: PC register, 2-deep pending-PC FIFO and 2-entry instruction buffer feeding decode; addr_ok->fs_valid is 2 cycles.
// Requests are withheld while pending+buffered+discard reaches 2, so responses always have a slot. Optional feature: FETCH_ADEF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0340_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_instr,
  output logic        fs_adef
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adef;
  } fs_entry_t;

  logic [31:0] pc_q;
  logic [1:0]  discard_cnt;
  logic [1:0]  pend_cnt;
  logic [1:0]  buf_cnt;
  logic [31:0] pend_head;
  fs_entry_t   buf_in;
  fs_entry_t   buf_head;
  logic [3:0]  occupancy;
  logic        room;
  logic        fetch_blk;
  logic        req_acc;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        adef_push;
  logic        buf_push;
  logic        buf_pop;
  logic [31:0] target;
  logic [2:0]  redirect_dis;

  assign occupancy = {2'b00, pend_cnt} + {2'b00, buf_cnt} + {2'b00, discard_cnt};
  assign room      = occupancy < 4'd2;

`ifdef FETCH_ADEF_EN
  logic halt;
  logic adef_fault;

  // A misaligned PC becomes a NOP fault entry, queued behind all older responses.
  assign adef_fault = pc_q[1:0] != 2'b00;
  assign fetch_blk  = halt || adef_fault;
  assign adef_push  = resetn && adef_fault && !halt && !br_taken &&
                      (pend_cnt == 2'd0) && (buf_cnt != 2'd2);
  assign target     = br_target;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      halt <= 1'b0;
    end else if (br_taken) begin
      halt <= 1'b0;
    end else if (adef_push) begin
      halt <= 1'b1;
    end
  end
`else
  assign fetch_blk = 1'b0;
  assign adef_push = 1'b0;
  assign target    = br_target & ~32'h3;
`endif

  assign inst_req  = resetn && !br_taken && !fetch_blk && room;
  assign inst_addr = pc_q;
  assign req_acc   = inst_req && inst_addr_ok;
  assign rsp_drop  = inst_data_ok && (discard_cnt != 2'd0);
  assign rsp_keep  = inst_data_ok && (discard_cnt == 2'd0) && (pend_cnt != 2'd0);
  assign buf_push  = rsp_keep || adef_push;
  assign buf_pop   = fs_valid && ds_allowin;

  always_comb begin
    buf_in = '{pc: pc_q, instr: NOP_INSTR, adef: 1'b1};
    if (rsp_keep) begin
      buf_in = '{pc: pend_head, instr: inst_rdata, adef: 1'b0};
    end
  end

  // Every request still in flight at a redirect belongs to the dead path; a same-cycle response is one of them.
  always_comb begin
    redirect_dis = {1'b0, discard_cnt} + {1'b0, pend_cnt};
    if (inst_data_ok && (redirect_dis != 3'd0)) begin
      redirect_dis = redirect_dis - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q        <= RESET_PC;
      discard_cnt <= 2'd0;
    end else if (br_taken) begin
      pc_q        <= target;
      discard_cnt <= redirect_dis[2] ? 2'd3 : redirect_dis[1:0];
    end else begin
      if (req_acc) begin
        pc_q <= pc_q + 32'd4;
      end
      if (rsp_drop) begin
        discard_cnt <= discard_cnt - 2'd1;
      end
    end
  end

  sync_fifo #(.W(32), .DEPTH(2)) u_pend (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (br_taken),
    .push     (req_acc),
    .push_dat (pc_q),
    .pop      (rsp_keep),
    .pop_dat  (pend_head),
    .cnt      (pend_cnt)
  );

  sync_fifo #(.W($bits(fs_entry_t)), .DEPTH(2)) u_buf (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (br_taken),
    .push     (buf_push),
    .push_dat (buf_in),
    .pop      (buf_pop),
    .pop_dat  (buf_head),
    .cnt      (buf_cnt)
  );

  assign fs_valid = buf_cnt != 2'd0;
  assign fs_pc    = buf_head.pc;
  assign fs_instr = buf_head.instr;
  assign fs_adef  = buf_head.adef;

  a_addr_stable: assert property (@(posedge clk) disable iff (!resetn)
    (inst_req && !inst_addr_ok) |=> (inst_addr == $past(inst_addr)));

endmodule

module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && (int'(cnt) < DEPTH);
  assign do_pop  = pop && (cnt != '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(push && !flush && (int'(cnt) == DEPTH)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table of per-cycle bus/decode stimulus with hand-computed fetch outputs, plus an asynchronous mid-cycle reset sequence.
module tb_fetch_stage;

  localparam logic [31:0] B   = 32'h1c00_0000;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        ds_allowin = 1'b0;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_instr;
  logic        fs_adef;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .ds_allowin   (ds_allowin),
    .fs_valid     (fs_valid),
    .fs_pc        (fs_pc),
    .fs_instr     (fs_instr),
    .fs_adef      (fs_adef)
  );

  typedef struct {
    bit          rst;
    bit          aok;
    bit          dok;
    logic [31:0] rsp;
    bit          br;
    logic [31:0] tgt;
    bit          alw;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_vld;
    logic [31:0] e_pc;
    bit          e_adef;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] word(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0000;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit aok, input bit dok, input logic [31:0] rsp,
                     input bit br, input logic [31:0] tgt, input bit alw,
                     input bit e_req, input logic [31:0] e_addr,
                     input bit e_vld, input logic [31:0] e_pc, input bit e_adef);
    vec_t v;
    v = '{rst, aok, dok, rsp, br, tgt, alw, e_req, e_addr, e_vld, e_pc, e_adef};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    br_taken     = 1'b0;
    br_target    = 32'h0;
    ds_allowin   = 1'b0;
  endtask

  task automatic do_reset(input int idx);
    @(negedge clk);
    drive_idle();
    resetn = 1'b0;
    #1;
    chk("rst_req", idx, inst_req, 1'b0);
    chk("rst_addr", idx, inst_addr, B);
    chk("rst_vld", idx, fs_valid, 1'b0);
    chk("rst_pc", idx, fs_pc, 32'h0);
    chk("rst_instr", idx, fs_instr, 32'h0);
    chk("rst_adef", idx, fs_adef, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    // Zero-wait bus, decode always ready.
    add(1,1,0,0,       0,0,1, 1,B,          0,0,0);
    add(0,1,1,B,       0,0,1, 1,B+32'h4,    0,0,0);
    add(0,1,1,B+32'h4, 0,0,1, 0,B+32'h8,    1,B,0);
    add(0,1,0,0,       0,0,1, 1,B+32'h8,    1,B+32'h4,0);
    add(0,1,1,B+32'h8, 0,0,1, 1,B+32'hc,    0,0,0);
    add(0,1,1,B+32'hc, 0,0,1, 0,B+32'h10,   1,B+32'h8,0);
    add(0,0,0,0,       0,0,1, 1,B+32'h10,   1,B+32'hc,0);
    // Decode stalled: buffer fills to 2, requests stop, then drain in order.
    add(1,1,0,0,       0,0,0, 1,B,          0,0,0);
    add(0,1,1,B,       0,0,0, 1,B+32'h4,    0,0,0);
    add(0,1,1,B+32'h4, 0,0,0, 0,B+32'h8,    1,B,0);
    for (int k = 0; k < 4; k++) add(0,1,0,0, 0,0,0, 0,B+32'h8, 1,B,0);
    add(0,1,0,0,       0,0,1, 0,B+32'h8,    1,B,0);
    add(0,0,0,0,       0,0,1, 1,B+32'h8,    1,B+32'h4,0);
    add(0,0,0,0,       0,0,1, 1,B+32'h8,    0,0,0);
    // Two requests outstanding, redirect, both late responses dropped.
    add(1,1,0,0,         0,0,1,          1,B,          0,0,0);
    add(0,1,0,0,         0,0,1,          1,B+32'h4,    0,0,0);
    add(0,1,0,0,         0,0,1,          0,B+32'h8,    0,0,0);
    add(0,1,0,0,         0,0,1,          0,B+32'h8,    0,0,0);
    add(0,1,0,0,         1,B+32'h100,1,  0,B+32'h8,    0,0,0);
    add(0,1,1,B,         0,0,1,          0,B+32'h100,  0,0,0);
    add(0,1,1,B+32'h4,   0,0,1,          1,B+32'h100,  0,0,0);
    add(0,1,1,B+32'h100, 0,0,1,          1,B+32'h104,  0,0,0);
    add(0,1,1,B+32'h104, 0,0,1,          0,B+32'h108,  1,B+32'h100,0);
    add(0,0,0,0,         0,0,1,          1,B+32'h108,  1,B+32'h104,0);
    // Redirect coincident with the response for 1c000008, 1c00000c still in flight.
    add(1,1,0,0,         0,0,1,          1,B,          0,0,0);
    add(0,1,1,B,         0,0,1,          1,B+32'h4,    0,0,0);
    add(0,1,1,B+32'h4,   0,0,1,          0,B+32'h8,    1,B,0);
    add(0,1,0,0,         0,0,1,          1,B+32'h8,    1,B+32'h4,0);
    add(0,1,0,0,         0,0,1,          1,B+32'hc,    0,0,0);
    add(0,1,1,B+32'h8,   1,B+32'h300,1,  0,B+32'h10,   0,0,0);
    add(0,1,1,B+32'hc,   0,0,1,          1,B+32'h300,  0,0,0);
    add(0,1,1,B+32'h300, 0,0,1,          1,B+32'h304,  0,0,0);
    add(0,1,1,B+32'h304, 0,0,1,          0,B+32'h308,  1,B+32'h300,0);
    add(0,0,0,0,         0,0,1,          1,B+32'h308,  1,B+32'h304,0);
    // Misaligned redirect target.
    add(1,1,0,0,         0,0,1,          1,B,          0,0,0);
    add(0,0,1,B,         1,B+32'h102,1,  0,B+32'h4,    0,0,0);
`ifdef FETCH_ADEF_EN
    add(0,1,0,0,         0,0,0,          0,B+32'h102,  0,0,0);
    add(0,1,0,0,         0,0,0,          0,B+32'h102,  1,B+32'h102,1);
    add(0,1,0,0,         0,0,1,          0,B+32'h102,  1,B+32'h102,1);
    add(0,1,0,0,         0,0,1,          0,B+32'h102,  0,0,0);
    add(0,1,0,0,         1,B+32'h200,1,  0,B+32'h102,  0,0,0);
    add(0,0,0,0,         0,0,1,          1,B+32'h200,  0,0,0);
`else
    add(0,1,0,0,         0,0,1,          1,B+32'h100,  0,0,0);
    add(0,0,1,B+32'h100, 0,0,1,          1,B+32'h104,  0,0,0);
    add(0,0,0,0,         0,0,1,          1,B+32'h104,  1,B+32'h100,0);
    add(0,0,0,0,         0,0,1,          1,B+32'h104,  0,0,0);
`endif
    // PC increment wraps from the top of the address space.
    add(1,0,0,0,            1,32'hffff_fffc,1, 0,B,             0,0,0);
    add(0,1,0,0,            0,0,1,             1,32'hffff_fffc, 0,0,0);
    add(0,0,1,32'hffff_fffc,0,0,1,             1,32'h0,         0,0,0);
    add(0,0,0,0,            0,0,1,             1,32'h0,         1,32'hffff_fffc,0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset(i);
      else @(negedge clk);
      inst_addr_ok = vecs[i].aok;
      inst_data_ok = vecs[i].dok;
      inst_rdata   = vecs[i].dok ? word(vecs[i].rsp) : 32'h0;
      br_taken     = vecs[i].br;
      br_target    = vecs[i].tgt;
      ds_allowin   = vecs[i].alw;
      #1;
      chk("req", i, inst_req, vecs[i].e_req);
      chk("addr", i, inst_addr, vecs[i].e_addr);
      chk("vld", i, fs_valid, vecs[i].e_vld);
      if (vecs[i].e_vld) begin
        chk("pc", i, fs_pc, vecs[i].e_pc);
        chk("instr", i, fs_instr, vecs[i].e_adef ? NOP : word(vecs[i].e_pc));
        chk("adef", i, fs_adef, vecs[i].e_adef);
      end
    end

    // Asynchronous reset between clock edges with two entries buffered.
    do_reset(900);
    inst_addr_ok = 1'b1;
    #1;
    chk("g_req0", 900, inst_req, 1'b1);
    @(negedge clk);
    inst_data_ok = 1'b1;
    inst_rdata   = word(B);
    @(negedge clk);
    inst_rdata   = word(B + 32'h4);
    @(negedge clk);
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b0;
    #1;
    chk("g_vld_full", 901, fs_valid, 1'b1);
    chk("g_req_full", 901, inst_req, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("g_vld_async", 902, fs_valid, 1'b0);
    chk("g_req_async", 902, inst_req, 1'b0);
    chk("g_addr_async", 902, inst_addr, B);
    chk("g_pc_async", 902, fs_pc, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("g_req_after", 903, inst_req, 1'b1);
    chk("g_addr_after", 903, inst_addr, B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
